// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared op codes, FSM states and instruction field positions
package datapath_pkg;

    localparam int INSTR_W = 9;
    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS1_MSB = 3;
    localparam int RS1_LSB = 2;
    localparam int RS2_MSB = 1;
    localparam int RS2_LSB = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR};
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// rtl/seq_fifo.sv - instruction queue with pointers, occupancy count and full/empty flags
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A push into a full queue is refused even when a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == COUNT_FULL);
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - queued instruction sequencer driving a register-file datapath in SETUP/WRITE pairs
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [1:0]       addr1,
    output logic [1:0]       addr2,
    output logic [1:0]       addr3,
    output logic [2:0]       alucontrol,
    output logic             wr,
    output logic             busy,
    output logic             retire,
    output logic             err,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t               state;
    state_t               next_state;
    logic [INSTR_W-1:0]   head;
    logic [INSTR_W-1:0]   issue_reg;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 drop;

    assign instr_ready = ~full & ~rst;
    assign push        = instr_valid & instr_ready;

    seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (instr),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // IDLE and WRITE both look at the head, which gives the 2-cycle issue cadence.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        issue      = 1'b0;
        drop       = 1'b0;
        case (state)
            ST_IDLE, ST_WRITE: begin
                next_state = ST_IDLE;
                if (!empty) begin
                    pop = 1'b1;
                    if (op_legal(head[OP_MSB:OP_LSB])) begin
                        issue      = 1'b1;
                        next_state = ST_SETUP;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_SETUP: next_state = ST_WRITE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            issue_reg   <= '0;
            err         <= 1'b0;
            retired_cnt <= '0;
            err_cnt     <= '0;
        end else begin
            state <= next_state;
            err   <= drop;
            if (issue) begin
                issue_reg <= head;
            end
            if (drop) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (state == ST_WRITE) begin
                retired_cnt <= retired_cnt + 1'b1;
            end
        end
    end

    assign addr1      = issue_reg[RS1_MSB:RS1_LSB];
    assign addr2      = issue_reg[RS2_MSB:RS2_LSB];
    assign addr3      = issue_reg[RD_MSB:RD_LSB];
    assign alucontrol = issue_reg[OP_MSB:OP_LSB];
    assign wr         = (state == ST_WRITE);
    assign retire     = (state == ST_WRITE);
    assign busy       = (state != ST_IDLE) | ~empty;

endmodule

// File: tb/tb_datapath_seq.sv
// tb/tb_datapath_seq.sv - self-checking bench for datapath_seq against a queue-based reference model
module tb_datapath_seq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [8:0]  instr = '0;

    logic        instr_ready, wr, busy, retire, err;
    logic [1:0]  addr1, addr2, addr3;
    logic [2:0]  alucontrol;
    logic [15:0] retired_cnt, err_cnt;

    logic        instr_ready_n, wr_n, busy_n, retire_n, err_n;
    logic [1:0]  addr1_n, addr2_n, addr3_n;
    logic [2:0]  alucontrol_n;
    logic [3:0]  retired_cnt_n, err_cnt_n;

    datapath_seq #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .alucontrol(alucontrol), .wr(wr), .busy(busy), .retire(retire), .err(err),
        .retired_cnt(retired_cnt), .err_cnt(err_cnt)
    );

    datapath_seq #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready_n), .addr1(addr1_n), .addr2(addr2_n), .addr3(addr3_n),
        .alucontrol(alucontrol_n), .wr(wr_n), .busy(busy_n), .retire(retire_n), .err(err_n),
        .retired_cnt(retired_cnt_n), .err_cnt(err_cnt_n)
    );

    always #5 clk = ~clk;

    // Model: accepted instructions, issue stage (0 idle, 1 setup, 2 write), last issued word.
    logic [8:0]  mq[$];
    int          stage = 0;
    logic [8:0]  m_issue = '0;
    int unsigned m_ret = 0;
    int unsigned m_errs = 0;
    logic        m_err = 1'b0;
    bit          check_en = 1'b0;
    logic        prev_wr = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int         pre;
        bit         acc;
        int         ns;
        logic [8:0] h;
        if (rst) begin
            mq.delete();
            stage   = 0;
            m_issue = '0;
            m_ret   = 0;
            m_errs  = 0;
            m_err   = 1'b0;
        end else begin
            pre   = mq.size();
            acc   = instr_valid && (pre < DEPTH);
            m_err = 1'b0;
            if (stage == 2) m_ret++;
            if (stage != 1 && pre > 0) begin
                h = mq.pop_front();
                if (h[8]) begin
                    m_errs++;
                    m_err = 1'b1;
                    ns = 0;
                end else begin
                    m_issue = h;
                    ns = 1;
                end
            end else begin
                ns = (stage == 1) ? 2 : 0;
            end
            if (acc) mq.push_back(instr);
            stage = ns;
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [8:0] i);
        rst = r;
        instr_valid = v;
        instr = i;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 9'h000);
        check("rst_ready", {31'b0, instr_ready}, 32'd0);
        check("rst_wr", {31'b0, wr}, 32'd0);
        check("rst_cnt", {16'b0, retired_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, instr_ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("ready", {31'b0, instr_ready}, {31'b0, (!rst && mq.size() < DEPTH)});
            check("busy", {31'b0, busy}, {31'b0, (stage != 0 || mq.size() > 0)});
            check("wr", {31'b0, wr}, {31'b0, (stage == 2)});
            check("retire", {31'b0, retire}, {31'b0, (stage == 2)});
            check("err", {31'b0, err}, {31'b0, m_err});
            check("addr1", {30'b0, addr1}, {30'b0, m_issue[3:2]});
            check("addr2", {30'b0, addr2}, {30'b0, m_issue[1:0]});
            check("addr3", {30'b0, addr3}, {30'b0, m_issue[5:4]});
            check("alu", {29'b0, alucontrol}, {29'b0, m_issue[8:6]});
            check("retired_cnt", {16'b0, retired_cnt}, m_ret & 32'hFFFF);
            check("err_cnt", {16'b0, err_cnt}, m_errs & 32'hFFFF);
            check("retired_cnt4", {28'b0, retired_cnt_n}, m_ret & 32'hF);
            check("err_cnt4", {28'b0, err_cnt_n}, m_errs & 32'hF);
            check("wr_consec", {31'b0, prev_wr & wr}, 32'd0);
            prev_wr = wr;
        end
    end

    initial begin
        logic [8:0] seq [4];
        logic [7:0] wrs;
        logic [11:0] alus;
        int         acc_cnt;

        cyc(1'b1, 1'b0, 9'h000);
        cyc(1'b1, 1'b0, 9'h000);
        check_en = 1'b1;

        // Single ADD R0 <- R1 + R2.
        do_reset();
        cyc(1'b0, 1'b1, 9'h006);
        cyc(1'b0, 1'b0, 9'h000);
        check("t1_setup_wr", {31'b0, wr}, 32'd0);
        check("t1_addrs", {24'b0, addr1, addr2, addr3, 2'b00}, {24'b0, 2'd1, 2'd2, 2'd0, 2'b00});
        check("t1_alu", {29'b0, alucontrol}, 32'd0);
        cyc(1'b0, 1'b0, 9'h000);
        check("t1_write", {30'b0, wr, retire}, 32'd3);
        cyc(1'b0, 1'b0, 9'h000);
        check("t1_retired", {16'b0, retired_cnt}, 32'd1);
        check("t1_idle_busy", {31'b0, busy}, 32'd0);

        // Back-to-back ADD, AND, XOR, SUB.
        seq = '{9'h006, 9'h09B, 9'h0E8, 9'h07D};
        do_reset();
        cyc(1'b0, 1'b1, seq[0]);
        wrs = '0;
        alus = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < 3) cyc(1'b0, 1'b1, seq[k+1]);
            else       cyc(1'b0, 1'b0, 9'h000);
            wrs = {wrs[6:0], wr};
            if (!wr) alus = {alus[8:0], alucontrol};
        end
        check("t2_wr_pattern", {24'b0, wrs}, 32'h55);
        check("t2_alu_order", {20'b0, alus}, {20'b0, 3'b000, 3'b010, 3'b011, 3'b001});
        cyc(1'b0, 1'b0, 9'h000);
        check("t2_retired", {16'b0, retired_cnt}, 32'd4);

        // Continuous pushes: queue fills after seven acceptances, refills after a pop.
        do_reset();
        acc_cnt = 0;
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, {3'b000, 6'(k)});
        check("t3_full_ready", {31'b0, instr_ready}, 32'd0);
        cyc(1'b0, 1'b1, 9'h03F);
        check("t3_ready_back", {31'b0, instr_ready}, 32'd1);
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 9'h000);

        // Illegal op dropped, then ADD issues.
        do_reset();
        cyc(1'b0, 1'b1, 9'h106);
        cyc(1'b0, 1'b1, 9'h006);
        check("t4_err", {31'b0, err}, 32'd1);
        check("t4_err_cnt", {16'b0, err_cnt}, 32'd1);
        check("t4_no_wr", {31'b0, wr}, 32'd0);
        cyc(1'b0, 1'b0, 9'h000);
        check("t4_add_setup", {27'b0, alucontrol, addr1}, {27'b0, 3'b000, 2'd1});
        check("t4_err_once", {31'b0, err}, 32'd0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 9'h000);

        // Reset during WRITE of the second of three.
        do_reset();
        cyc(1'b0, 1'b1, 9'h006);
        cyc(1'b0, 1'b1, 9'h09B);
        cyc(1'b0, 1'b1, 9'h0E8);
        cyc(1'b0, 1'b0, 9'h000);
        cyc(1'b0, 1'b0, 9'h000);
        check("t5_in_write", {29'b0, wr, alucontrol[1:0]}, {29'b0, 1'b1, 2'b10});
        cyc(1'b1, 1'b0, 9'h000);
        check("t5_wr", {31'b0, wr}, 32'd0);
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_cnts", {retired_cnt, err_cnt}, 32'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 9'h000);
        check("t5_still_idle", {31'b0, busy}, 32'd0);

        // Narrow counter wraps after 17 retirements.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            cyc(1'b0, 1'b1, 9'h0E4);
            cyc(1'b0, 1'b0, 9'h000);
            cyc(1'b0, 1'b0, 9'h000);
        end
        cyc(1'b0, 1'b0, 9'h000);
        check("t6_wrap4", {28'b0, retired_cnt_n}, 32'd1);
        check("t6_cnt16", {16'b0, retired_cnt}, 32'd17);

        // Randomised traffic with occasional illegal ops and resets.
        for (int k = 0; k < 3000; k++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 3) == 0) ? {1'b1, 2'($urandom)} : {1'b0, 2'($urandom)};
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), {op, 6'($urandom)});
        end
        for (int k = 0; k < 12; k++) cyc(1'b0, 1'b0, 9'h000);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
